data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressed, little-endian data memory for the RISC-V core's load/store path.
- Successor to the fixed 128-byte combinational-read store; sits between the LSU and local data RAM.
- Adds:
  - valid/ready request handshake
  - configurable wait states
  - registered response
  - load sign/zero extension
  - misalignment and out-of-range error reporting
  - a hardware clear sequencer after reset

---
 rtl/data_memory_ctrl_if.sv | 31 +++
 rtl/data_memory_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// LSU <-> data memory request/response bundle.
// master drives requests, slave answers.
interface data_memory_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic                  init_busy;

   modport master (
      output req_valid, req_we, req_addr,
      output req_size, req_unsigned, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  rsp_err, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr,
      input  req_size, req_unsigned, req_wdata,
      output req_ready, rsp_valid, rsp_rdata,
      output rsp_err, init_busy
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with
// wait states, registered response and clear-on-reset.
module data_memory_ctrl #(
   parameter int DEPTH_BYTES = 128,
   parameter int WAIT_STATES = 1,
   parameter int ADDR_WIDTH  = 32
) (
   input logic               clk,
   input logic               resetn,
   data_memory_ctrl_if.slave bus
);
   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int LB    = $clog2(DEPTH_BYTES);
   localparam int IW    = LB - 2;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_WAIT, S_ACCESS, S_RESP
   } state_t;

   state_t                state, state_nx;
   logic [IW-1:0]         clear_ptr;
   logic [3:0]            wait_cnt;
   logic                  cap_we;
   logic                  cap_uns;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [1:0]            cap_size;
   logic [31:0]           cap_wdata;
   logic [31:0]           rdata_q;
   logic                  err_q;
   logic [31:0]           mem [WORDS];

   logic [1:0]    off;
   logic [IW-1:0] widx;
   logic          err;
   logic [3:0]    be;
   logic [31:0]   wd;
   logic [31:0]   rword;
   logic [31:0]   rsh;
   logic [31:0]   ldata;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_INIT;
      else         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_INIT:
            if (clear_ptr == IW'(WORDS - 1))
               state_nx = S_IDLE;
         S_IDLE:
            if (bus.req_valid)
               state_nx = (WAIT_STATES > 0) ? S_WAIT
                                            : S_ACCESS;
         S_WAIT:
            if (wait_cnt == 4'(WAIT_STATES - 1))
               state_nx = S_ACCESS;
         S_ACCESS: state_nx = S_RESP;
         S_RESP:   state_nx = S_IDLE;
         default:  state_nx = S_INIT;
      endcase
   end

   // handshake and status outputs
   always_comb begin
      bus.req_ready = (state == S_IDLE);
      bus.rsp_valid = (state == S_RESP);
      bus.init_busy = (state == S_INIT);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
   end

   // clear pointer and wait-state counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clear_ptr <= '0;
         wait_cnt  <= '0;
      end else begin
         if (state == S_INIT) clear_ptr <= clear_ptr + 1'b1;
         if (state == S_WAIT) wait_cnt  <= wait_cnt + 1'b1;
         else                 wait_cnt  <= '0;
      end
   end

   // capture the accepted request
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_we    <= 1'b0;
         cap_uns   <= 1'b0;
         cap_addr  <= '0;
         cap_size  <= 2'b00;
         cap_wdata <= '0;
      end else if (state == S_IDLE && bus.req_valid) begin
         cap_we    <= bus.req_we;
         cap_uns   <= bus.req_unsigned;
         cap_addr  <= bus.req_addr;
         cap_size  <= bus.req_size;
         cap_wdata <= bus.req_wdata;
      end
   end

   // legality, lane enables and load extension
   always_comb begin
      off   = cap_addr[1:0];
      widx  = cap_addr[LB-1:2];
      err   = cap_addr >= ADDR_WIDTH'(DEPTH_BYTES);
      be    = 4'b0000;
      wd    = cap_wdata << {off, 3'b000};
      rword = mem[widx];
      rsh   = rword >> {off, 3'b000};
      ldata = rword;
      unique case (cap_size)
         2'b00: begin
            be    = 4'b0001 << off;
            ldata = cap_uns ? {24'b0, rsh[7:0]}
                            : {{24{rsh[7]}}, rsh[7:0]};
         end
         2'b01: begin
            be    = 4'b0011 << off;
            err   = err | off[0];
            ldata = cap_uns ? {16'b0, rsh[15:0]}
                            : {{16{rsh[15]}}, rsh[15:0]};
         end
         2'b10: begin
            be  = 4'b1111;
            err = err | (off != 2'b00);
         end
         default: err = 1'b1;
      endcase
   end

   // registered response, held until the next access
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state == S_ACCESS) begin
         rdata_q <= (err || cap_we) ? 32'b0 : ldata;
         err_q   <= err;
      end
   end

   // storage: clear sweep, then byte-enabled stores
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         mem[clear_ptr] <= 32'b0;
      end else if (state == S_ACCESS && cap_we && !err) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: two instances,
// WAIT_STATES=1 (main) and WAIT_STATES=0 (throughput).
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   logic resetn;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_ctrl_if #(.ADDR_WIDTH(32)) b1 ();
   data_memory_ctrl_if #(.ADDR_WIDTH(32)) b0 ();

   data_memory_ctrl #(
      .DEPTH_BYTES(128), .WAIT_STATES(1), .ADDR_WIDTH(32)
   ) u_dut1 (.clk(clk), .resetn(resetn), .bus(b1.slave));

   data_memory_ctrl #(
      .DEPTH_BYTES(128), .WAIT_STATES(0), .ADDR_WIDTH(32)
   ) u_dut0 (.clk(clk), .resetn(resetn), .bus(b0.slave));

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h",
                  tag, got, exp);
      end
   endtask

   task automatic xfer(input bit we,
                       input logic [31:0] addr,
                       input logic [1:0] size,
                       input bit uns,
                       input logic [31:0] wdata,
                       output logic [31:0] rd,
                       output logic err);
      int t;
      @(negedge clk);
      b1.req_valid    = 1'b1;
      b1.req_we       = we;
      b1.req_addr     = addr;
      b1.req_size     = size;
      b1.req_unsigned = uns;
      b1.req_wdata    = wdata;
      t = 0;
      while (!b1.req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!b1.req_ready)
         check("accept_timeout", {31'b0, b1.req_ready}, 1);
      @(posedge clk);
      #1 b1.req_valid = 1'b0;
      @(negedge clk);
      t = 0;
      while (!b1.rsp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!b1.rsp_valid) begin
         check("rsp_timeout", {31'b0, b1.rsp_valid}, 1);
         rd  = 32'hxxxxxxxx;
         err = 1'bx;
      end else begin
         rd  = b1.rsp_rdata;
         err = b1.rsp_err;
      end
   endtask

   task automatic ld(input string tag,
                     input logic [31:0] addr,
                     input logic [1:0] size,
                     input bit uns,
                     input logic [31:0] exp);
      logic [31:0] rd;
      logic        e;
      xfer(1'b0, addr, size, uns, 32'h0, rd, e);
      check(tag, rd, exp);
      check({tag, "_err"}, {31'b0, e}, 0);
   endtask

   task automatic st(input string tag,
                     input logic [31:0] addr,
                     input logic [1:0] size,
                     input logic [31:0] wdata);
      logic [31:0] rd;
      logic        e;
      xfer(1'b1, addr, size, 1'b0, wdata, rd, e);
      check({tag, "_err"}, {31'b0, e}, 0);
   endtask

   task automatic bad(input string tag,
                      input bit we,
                      input logic [31:0] addr,
                      input logic [1:0] size,
                      input logic [31:0] wdata);
      logic [31:0] rd;
      logic        e;
      xfer(we, addr, size, 1'b0, wdata, rd, e);
      check({tag, "_err"}, {31'b0, e}, 1);
      check({tag, "_rdata"}, rd, 0);
   endtask

   task automatic wait_init(input string tag);
      int cnt;
      int odd;
      cnt = 0;
      odd = 0;
      while (b1.init_busy && cnt < 100) begin
         if (b1.req_ready || b1.rsp_valid) odd++;
         cnt++;
         @(negedge clk);
      end
      check({tag, "_len"}, cnt, 32);
      check({tag, "_quiet"}, odd, 0);
   endtask

   task automatic thru(input string tag, input bit sel,
                       input int period, input int lat);
      int a[2];
      int r[2];
      int na;
      int nr;
      int t;
      logic rdy;
      logic rv;
      na = 0;
      nr = 0;
      t  = 0;
      @(negedge clk);
      if (sel) begin
         b0.req_valid = 1'b1; b0.req_we = 1'b0;
         b0.req_addr = 32'h0; b0.req_size = 2'b10;
      end else begin
         b1.req_valid = 1'b1; b1.req_we = 1'b0;
         b1.req_addr = 32'h0; b1.req_size = 2'b10;
      end
      while (nr < 2 && t < 40) begin
         rdy = sel ? b0.req_ready : b1.req_ready;
         rv  = sel ? b0.rsp_valid : b1.rsp_valid;
         if (rdy && na < 2) begin
            a[na] = cyc + 1;
            na++;
         end
         if (rv) begin
            r[nr] = cyc;
            nr++;
         end
         t++;
         @(negedge clk);
      end
      b0.req_valid = 1'b0;
      b1.req_valid = 1'b0;
      check({tag, "_npulse"}, nr, 2);
      check({tag, "_period"}, a[1] - a[0], period);
      check({tag, "_lat"}, r[0] - a[0], lat);
      check({tag, "_rsp_gap"}, r[1] - r[0], period);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic seen;
      resetn = 1'b0;
      b1.req_valid = 1'b0; b1.req_we = 1'b0;
      b1.req_addr = '0;    b1.req_size = 2'b00;
      b1.req_unsigned = 1'b0; b1.req_wdata = '0;
      b0.req_valid = 1'b0; b0.req_we = 1'b0;
      b0.req_addr = '0;    b0.req_size = 2'b00;
      b0.req_unsigned = 1'b0; b0.req_wdata = '0;
      #1;
      check("rst_ready", {31'b0, b1.req_ready}, 0);
      check("rst_rsp_valid", {31'b0, b1.rsp_valid}, 0);
      check("rst_rsp_err", {31'b0, b1.rsp_err}, 0);
      check("rst_rdata", b1.rsp_rdata, 0);
      check("rst_init_busy", {31'b0, b1.init_busy}, 1);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      wait_init("init");
      ld("lw_7c", 32'h7C, 2'b10, 1'b0, 32'h0);

      st("sw_00", 32'h00, 2'b10, 32'hF00F81AA);
      ld("lb_00", 32'h00, 2'b00, 1'b0, 32'hFFFFFFAA);
      ld("lbu_01", 32'h01, 2'b00, 1'b1, 32'h00000081);
      ld("lh_02", 32'h02, 2'b01, 1'b0, 32'hFFFFF00F);
      ld("lhu_02", 32'h02, 2'b01, 1'b1, 32'h0000F00F);

      st("sb_03", 32'h03, 2'b00, 32'h12345655);
      ld("lw_00a", 32'h00, 2'b10, 1'b0, 32'h550F81AA);
      st("sh_06", 32'h06, 2'b01, 32'h0000BEEF);
      ld("lw_04", 32'h04, 2'b10, 1'b0, 32'hBEEF0000);

      bad("lh_01", 1'b0, 32'h01, 2'b01, 32'h0);
      bad("lw_02", 1'b0, 32'h02, 2'b10, 32'h0);
      bad("size11", 1'b0, 32'h00, 2'b11, 32'h0);
      bad("sw_80", 1'b1, 32'h80, 2'b10, 32'hDEADBEEF);
      ld("lw_00b", 32'h00, 2'b10, 1'b0, 32'h550F81AA);

      thru("ws1", 1'b0, 4, 2);
      thru("ws0", 1'b1, 3, 1);

      st("sw_10", 32'h10, 2'b10, 32'h22222222);
      ld("lw_10a", 32'h10, 2'b10, 1'b0, 32'h22222222);
      @(negedge clk);
      b1.req_valid = 1'b1; b1.req_we = 1'b1;
      b1.req_addr = 32'h10; b1.req_size = 2'b10;
      b1.req_wdata = 32'h11111111;
      check("rst6_ready", {31'b0, b1.req_ready}, 1);
      @(posedge clk);
      #1 b1.req_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rst6_init_busy", {31'b0, b1.init_busy}, 1);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | b1.rsp_valid;
      end
      resetn = 1'b1;
      wait_init("reinit");
      check("rst6_no_rsp", {31'b0, seen}, 0);
      ld("lw_10b", 32'h10, 2'b10, 1'b0, 32'h0);
      ld("lw_00c", 32'h00, 2'b10, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule
